// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, funct codes,
// ALU function codes, datapath select encodings and FSM state codes.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic [1:0] SRC_B_REG     = 2'b00;
    localparam logic [1:0] SRC_B_FOUR    = 2'b01;
    localparam logic [1:0] SRC_B_IMM     = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_IMMEX  = 4'd9;
    localparam logic [3:0] S_IMMWB  = 4'd10;
    localparam logic [3:0] S_JUMP   = 4'd11;

    typedef struct packed {
        logic       mem_re;
        logic       mem_we;
        logic       iord;
        logic       ir_we;
        logic       pc_en;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       imm_zext;
        logic [2:0] alu_ctrl;
        logic       reg_w;
        logic       reg_d;
        logic       mem_to_reg;
        logic       instr_done;
        logic       illegal;
    } ctrl_t;

    function automatic logic funct_legal(input logic [5:0] f);
        return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
               (f == FN_OR)  || (f == FN_SLT);
    endfunction

    // andi/ori are logical ops on a zero-extended immediate; addi stays arithmetic.
    function automatic logic [2:0] imm_alu_ctrl(input logic [5:0] op);
        case (op)
            OP_ANDI: return ALU_AND;
            OP_ORI:  return ALU_OR;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mips_alu_dec.sv
// ALU function decoder: fixed ADD/SUB for address and compare steps, funct
// field decode for R-type execution.
module mips_alu_dec
    import mips_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alu_ctrl
);

    always_comb begin
        alu_ctrl = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_ctrl = ALU_ADD;
            ALUOP_SUB: alu_ctrl = ALU_SUB;
            default: begin
                case (funct)
                    FN_ADD:  alu_ctrl = ALU_ADD;
                    FN_SUB:  alu_ctrl = ALU_SUB;
                    FN_AND:  alu_ctrl = ALU_AND;
                    FN_OR:   alu_ctrl = ALU_OR;
                    FN_SLT:  alu_ctrl = ALU_SLT;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control FSM: sequences the shared ALU and unified memory port,
// drives all datapath selects/strobes, flags illegal instructions, counts retirements.
module mips_mc_ctrl
    import mips_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_re,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_we,
    output logic             pc_en,
    output logic [1:0]       pc_src,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             imm_zext,
    output logic [2:0]       alu_ctrl,
    output logic             reg_w,
    output logic             reg_d,
    output logic             mem_to_reg,
    output logic             instr_done,
    output logic             illegal,
    output logic [CNT_W-1:0] retired_cnt
);

    logic [3:0]       state_q, state_d, state_nx;
    logic             run_q;
    logic [CNT_W-1:0] retired_cnt_q, retired_cnt_d;
    logic [1:0]       alu_op;
    logic [2:0]       dec_alu_ctrl;
    ctrl_t            ctrl, ctrl_out;

    // run_q keeps every output at zero until the first edge after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_FETCH;
            run_q         <= 1'b0;
            retired_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            run_q         <= 1'b1;
            retired_cnt_q <= retired_cnt_d;
        end
    end

    assign alu_op = (state_q == S_BRANCH) ? ALUOP_SUB :
                    (state_q == S_EXEC)   ? ALUOP_FUNCT : ALUOP_ADD;

    mips_alu_dec u_alu_dec (
        .alu_op   (alu_op),
        .funct    (funct),
        .alu_ctrl (dec_alu_ctrl)
    );

    always_comb begin
        ctrl     = '0;
        state_nx = state_q;
        case (state_q)
            S_FETCH: begin
                ctrl.mem_re    = 1'b1;
                ctrl.alu_src_b = SRC_B_FOUR;
                ctrl.alu_ctrl  = dec_alu_ctrl;
                ctrl.pc_src    = PC_SRC_ALU;
                ctrl.ir_we     = mem_ready;
                ctrl.pc_en     = mem_ready;
                if (mem_ready) state_nx = S_DECODE;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRC_B_IMM_SH2;
                ctrl.alu_ctrl  = dec_alu_ctrl;
                case (op)
                    OP_LW, OP_SW:              state_nx = S_MEMADR;
                    OP_BEQ:                    state_nx = S_BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI:  state_nx = S_IMMEX;
                    OP_J:                      state_nx = S_JUMP;
                    OP_RTYPE: begin
                        if (funct_legal(funct)) begin
                            state_nx = S_EXEC;
                        end else begin
                            ctrl.illegal    = 1'b1;
                            ctrl.instr_done = 1'b1;
                            state_nx        = S_FETCH;
                        end
                    end
                    default: begin
                        ctrl.illegal    = 1'b1;
                        ctrl.instr_done = 1'b1;
                        state_nx        = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_IMM;
                ctrl.alu_ctrl  = dec_alu_ctrl;
                state_nx       = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                ctrl.mem_re = 1'b1;
                ctrl.iord   = 1'b1;
                if (mem_ready) state_nx = S_MEMWB;
            end
            S_MEMWB: begin
                ctrl.reg_w      = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.instr_done = 1'b1;
                state_nx        = S_FETCH;
            end
            S_MEMWR: begin
                ctrl.mem_we     = 1'b1;
                ctrl.iord       = 1'b1;
                ctrl.instr_done = mem_ready;
                if (mem_ready) state_nx = S_FETCH;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_REG;
                ctrl.alu_ctrl  = dec_alu_ctrl;
                state_nx       = S_ALUWB;
            end
            S_ALUWB: begin
                ctrl.reg_w      = 1'b1;
                ctrl.reg_d      = 1'b1;
                ctrl.instr_done = 1'b1;
                state_nx        = S_FETCH;
            end
            S_BRANCH: begin
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_src_b  = SRC_B_REG;
                ctrl.alu_ctrl   = dec_alu_ctrl;
                ctrl.pc_src     = PC_SRC_ALUOUT;
                ctrl.pc_en      = zero;
                ctrl.instr_done = 1'b1;
                state_nx        = S_FETCH;
            end
            S_IMMEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_IMM;
                ctrl.alu_ctrl  = imm_alu_ctrl(op);
                ctrl.imm_zext  = (op != OP_ADDI);
                state_nx       = S_IMMWB;
            end
            S_IMMWB: begin
                ctrl.reg_w      = 1'b1;
                ctrl.imm_zext   = (op != OP_ADDI);
                ctrl.instr_done = 1'b1;
                state_nx        = S_FETCH;
            end
            S_JUMP: begin
                ctrl.pc_src     = PC_SRC_JUMP;
                ctrl.pc_en      = 1'b1;
                ctrl.instr_done = 1'b1;
                state_nx        = S_FETCH;
            end
            default: state_nx = S_FETCH;
        endcase
    end

    always_comb begin
        ctrl_out      = run_q ? ctrl : '0;
        state_d       = run_q ? state_nx : state_q;
        retired_cnt_d = retired_cnt_q;
        if (ctrl_out.instr_done && !ctrl_out.illegal) begin
            retired_cnt_d = retired_cnt_q + CNT_W'(1);
        end
    end

    assign mem_re      = ctrl_out.mem_re;
    assign mem_we      = ctrl_out.mem_we;
    assign iord        = ctrl_out.iord;
    assign ir_we       = ctrl_out.ir_we;
    assign pc_en       = ctrl_out.pc_en;
    assign pc_src      = ctrl_out.pc_src;
    assign alu_src_a   = ctrl_out.alu_src_a;
    assign alu_src_b   = ctrl_out.alu_src_b;
    assign imm_zext    = ctrl_out.imm_zext;
    assign alu_ctrl    = ctrl_out.alu_ctrl;
    assign reg_w       = ctrl_out.reg_w;
    assign reg_d       = ctrl_out.reg_d;
    assign mem_to_reg  = ctrl_out.mem_to_reg;
    assign instr_done  = ctrl_out.instr_done;
    assign illegal     = ctrl_out.illegal;
    assign retired_cnt = retired_cnt_q;

endmodule
